regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the core datapath; successor to the 2-read/1-write file.
- Adds configurable read/write port counts, same-cycle write-to-read bypass, asynchronous reset clearing, and a per-register busy scoreboard with a reservation port.
- The decode stage reads operands and reserves destination registers. Writeback ports write results and release the reservations.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 2, number of write ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching reads.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r_reg  in  NUM_RD*ADDR_W  read indices; port i is bits [i*ADDR_W +: ADDR_W].
- r_dat  out  NUM_RD*DATA_W  read data; port i is bits [i*DATA_W +: DATA_W].
- r_busy  out  NUM_RD  scoreboard busy flag for each read index.
- w_en  in  NUM_WR  write enables.
- w_reg  in  NUM_WR*ADDR_W  write indices.
- w_dat  in  NUM_WR*DATA_W  write data.
- rsv_en  in  1  reserve destination register (set busy).
- rsv_reg  in  ADDR_W  register to reserve.
- busy_cnt  out  ADDR_W+1  number of registers currently busy.

Behaviour:
Reset and state
- Clock is one clock (clk); reset is asynchronous and active-low (rst_n).
- While rst_n=0, all registers read 0, all busy bits are 0 and busy_cnt=0.
- Reset asserted mid-operation clears state immediately, with no clock edge required.
- Reads after reset release return 0 until written.

Reads (combinational, zero latency)
- r_dat[i] = regs[r_reg[i]].
- If BYPASS=1 and any write port j has w_en[j]=1 with w_reg[j]==r_reg[i], then r_dat[i] = w_dat of the highest-index matching j.
- If ZERO_REG=1 and r_reg[i]==0, r_dat[i]=0 and r_busy[i]=0, overriding the bypass.
- r_busy[i] = busy[r_reg[i]], except when BYPASS=1 and a matching same-cycle write exists; then r_busy[i]=0.

Writes (registered on the rising clk edge)
- Each port with w_en[j]=1 updates regs[w_reg[j]].
- Two or more ports targeting the same register in the same cycle: the highest-index port wins.
- Writes to reg 0 are dropped when ZERO_REG=1.
- Writes land regardless of busy state; the scoreboard does not gate writes.

Scoreboard (registered on the rising clk edge)
- A write to register k clears busy[k].
- rsv_en=1 sets busy[rsv_reg].
- Reservation and write to the same register in the same cycle: the data is written and busy ends up SET (new reservation wins).
- Reserving an already-busy register leaves it busy; the count does not change.
- rsv_reg=0 with ZERO_REG=1 is ignored.
- busy_cnt is registered, equals the population count of the busy bits after each edge, and ranges 0..2**ADDR_W.

Widths and arithmetic
- No arithmetic on data.
- busy_cnt is one bit wider than ADDR_W so the all-busy count (32 for ADDR_W=5) is representable without wrap.

Test Plan:
1. Reset and zero register:
   - Stimulus: hold rst_n=0, then release; read indices 0 and 31. Write port 0 writes 0xDEADBEEF to reg 0, then read reg 0.
   - Required response: both reads return 0 and busy_cnt=0; after the write, reg 0 still reads 0.
2. Write-port conflict and bypass:
   - Stimulus: same cycle, w_en=2'b11, w_reg0=5, w_dat0=0x11, w_reg1=5, w_dat1=0x22; r_reg0=5.
   - Required response: r_dat0=0x22 in the same cycle. After the edge, reg 5 holds 0x22.
   - Repeat with BYPASS=0: required response is r_dat0 = old value (0x0) in the same cycle, then 0x22.
3. Scoreboard lifecycle:
   - Stimulus: reserve reg 7, then wait 3 cycles. Then write 0x55 to reg 7.
   - Required response: busy_cnt goes to 1 and r_busy=1 while reading reg 7. In the write cycle, r_busy=0 and r_dat=0x55 (bypass). After the edge, busy_cnt=0.
4. Simultaneous reserve and write:
   - Stimulus: rsv_reg=9 with w_reg0=9, w_dat0=0xA5 in the same cycle.
   - Required response: reg 9 = 0xA5, busy[9]=1, busy_cnt increments by 1.
5. Saturation:
   - Stimulus: reserve regs 0..31 over 32 cycles with ZERO_REG=1.
   - Required response: busy_cnt=31.
   - Repeat with ZERO_REG=0: required response is busy_cnt=32, with no wrap to 0.
6. Async reset mid-operation:
   - Stimulus: with 4 registers busy and data written, pulse rst_n low between clock edges.
   - Required response: busy_cnt=0 and all reads return 0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Decode/writeback bundle for the multi-port register file: operand reads, result writes,
// destination reservations and the live busy count.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   logic [NUM_RD*ADDR_W-1:0] r_reg;
   logic [NUM_RD*DATA_W-1:0] r_dat;
   logic [NUM_RD-1:0]        r_busy;
   logic [NUM_WR-1:0]        w_en;
   logic [NUM_WR*ADDR_W-1:0] w_reg;
   logic [NUM_WR*DATA_W-1:0] w_dat;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_reg;
   logic [ADDR_W:0]          busy_cnt;

   modport master (
      output r_reg, w_en, w_reg, w_dat, rsv_en, rsv_reg,
      input  r_dat, r_busy, busy_cnt
   );

   modport slave (
      input  r_reg, w_en, w_reg, w_dat, rsv_en, rsv_reg,
      output r_dat, r_busy, busy_cnt
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; reads are combinational with optional
// same-cycle write bypass, writes/reservations land on the clock edge, never stalls.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_mp_if.slave rf
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [ADDR_W:0]   cnt_q;
   logic [ADDR_W:0]   cnt_nxt;
   logic [ADDR_W-1:0] rd_idx;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] rd_d;
   logic              rd_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
      end else begin
         // Ascending loop: the last non-blocking assignment wins, so the highest port takes a conflict.
         for (int j = 0; j < NUM_WR; j++) begin
            if (rf.w_en[j] && !(ZERO_REG != 0 && rf.w_reg[j*ADDR_W +: ADDR_W] == '0))
               regs[rf.w_reg[j*ADDR_W +: ADDR_W]] <= rf.w_dat[j*DATA_W +: DATA_W];
         end
      end
   end

   // Writes release first, then a reservation re-sets, so reserve-and-write leaves the register busy.
   always_comb begin
      busy_nxt = busy;
      wr_idx   = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         wr_idx = rf.w_reg[j*ADDR_W +: ADDR_W];
         if (rf.w_en[j]) busy_nxt[wr_idx] = 1'b0;
      end
      if (rf.rsv_en) busy_nxt[rf.rsv_reg] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
      cnt_nxt = '0;
      for (int k = 0; k < DEPTH; k++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[k]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= '0;
         cnt_q <= '0;
      end else begin
         busy  <= busy_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   assign rf.busy_cnt = cnt_q;

   // Reset masks reads directly so a live write on the bus cannot leak through the bypass.
   always_comb begin
      rf.r_dat  = '0;
      rf.r_busy = '0;
      rd_idx    = '0;
      rd_d      = '0;
      rd_b      = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_idx = rf.r_reg[i*ADDR_W +: ADDR_W];
         rd_d   = regs[rd_idx];
         rd_b   = busy[rd_idx];
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (rf.w_en[j] && rf.w_reg[j*ADDR_W +: ADDR_W] == rd_idx) begin
                  rd_d = rf.w_dat[j*DATA_W +: DATA_W];
                  rd_b = 1'b0;
               end
            end
         end
         if ((ZERO_REG != 0 && rd_idx == '0) || !rst_n) begin
            rd_d = '0;
            rd_b = 1'b0;
         end
         rf.r_dat[i*DATA_W +: DATA_W] = rd_d;
         rf.r_busy[i]                 = rd_b;
      end
   end
endmodule
